// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - EX-stage iterative multiplier with HI/LO registers
// Build option: define MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
module mul_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_en_i,
   input  logic             flush_i,
   input  logic             sign_i,
   input  logic             we_i,
   input  logic             en_c_i,
   input  logic             add_sub_i,
   input  logic [1:0]       hilo_i,
   input  logic             mul_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   output logic             stall_o,
   output logic [WIDTH-1:0] hilo_rdata_o,
   output logic [WIDTH-1:0] mul_result_o,
   output logic             result_valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);
`ifdef MUL_RADIX4_EN
   localparam logic [CW-1:0] STEP = CW'(2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);
`else
   localparam logic [CW-1:0] STEP = CW'(1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

   typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               neg_q, en_c_q, add_sub_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   logic               is_mult, is_mt, start, mt_wr;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] a_ext, addend, prod, hilo_cur, hilo_new;

   // mul only selects the GPR destination upstream; the datapath treats it like mult
   logic unused_mul;
   assign unused_mul = mul_i;

   assign is_mult = we_i & (hilo_i == 2'b11);
   assign is_mt   = we_i & ((hilo_i == 2'b10) | (hilo_i == 2'b01));
   assign start   = (state == IDLE) & ex_en_i & is_mult & ~flush_i;
   assign mt_wr   = (state == IDLE) & ex_en_i & is_mt & ~flush_i;

   // magnitude of the operands; the most negative value maps onto itself as unsigned
   assign abs_a = (sign_i & rs_data_i[WIDTH-1]) ? (WIDTH'(0) - rs_data_i) : rs_data_i;
   assign abs_b = (sign_i & rt_data_i[WIDTH-1]) ? (WIDTH'(0) - rt_data_i) : rt_data_i;

   assign a_ext = {{WIDTH{1'b0}}, a_q};

   // partial product for the multiplier bit(s) selected by count
`ifdef MUL_RADIX4_EN
   logic [1:0] bits;
   logic [2*WIDTH-1:0] pp;
   always_comb begin
      bits = b_q[count +: 2];
      case (bits)
         2'b00:   pp = '0;
         2'b01:   pp = a_ext;
         2'b10:   pp = a_ext << 1;
         default: pp = a_ext + (a_ext << 1);
      endcase
      addend = pp << count;
   end
`else
   always_comb begin
      addend = b_q[count] ? (a_ext << count) : '0;
   end
`endif

   assign prod     = neg_q ? ((2*WIDTH)'(0) - acc) : acc;
   assign hilo_cur = {hi_o, lo_o};
   assign hilo_new = en_c_q ? (add_sub_q ? (hilo_cur - prod) : (hilo_cur + prod)) : prod;

   assign hilo_rdata_o = (hilo_i == 2'b10) ? hi_o :
                         (hilo_i == 2'b01) ? lo_o : '0;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next state, stall and completion pulse; a flush drops stall in the same cycle
   always_comb begin
      state_n        = state;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stall_o = 1'b1;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (flush_i) begin
               state_n = IDLE;
            end else begin
               stall_o = 1'b1;
               if (count == LAST) state_n = FIN;
            end
         end
         FIN: begin
            state_n        = IDLE;
            result_valid_o = ~flush_i;
         end
         default: state_n = IDLE;
      endcase
   end

   // operand latch, shift-add accumulation and HI/LO/result commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         neg_q        <= 1'b0;
         en_c_q       <= 1'b0;
         add_sub_q    <= 1'b0;
         acc          <= '0;
         count        <= '0;
         hi_o         <= '0;
         lo_o         <= '0;
         mul_result_o <= '0;
      end else begin
         if (start) begin
            a_q       <= abs_a;
            b_q       <= abs_b;
            neg_q     <= sign_i & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            en_c_q    <= en_c_i;
            add_sub_q <= add_sub_i;
            acc       <= '0;
            count     <= '0;
         end
         if (mt_wr) begin
            if (hilo_i == 2'b10) hi_o <= rs_data_i;
            else                 lo_o <= rs_data_i;
         end
         if ((state == BUSY) && !flush_i) begin
            acc   <= acc + addend;
            count <= count + STEP;
         end
         if (result_valid_o) begin
            hi_o         <= hilo_new[2*WIDTH-1:WIDTH];
            lo_o         <= hilo_new[WIDTH-1:0];
            mul_result_o <= prod[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - randomized model-checked bench for mul_hilo_unit
module tb_mul_hilo_unit;

   localparam int W = 32;
`ifdef MUL_RADIX4_EN
   localparam int LAT = 17;
`else
   localparam int LAT = 33;
`endif

   logic          clk, rst, ex_en_i, flush_i, sign_i, we_i, en_c_i, add_sub_i, mul_i;
   logic [1:0]    hilo_i;
   logic [W-1:0]  rs_data_i, rt_data_i;
   logic          stall_o, result_valid_o;
   logic [W-1:0]  hilo_rdata_o, mul_result_o, hi_o, lo_o;

   mul_hilo_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .ex_en_i(ex_en_i), .flush_i(flush_i), .sign_i(sign_i),
      .we_i(we_i), .en_c_i(en_c_i), .add_sub_i(add_sub_i), .hilo_i(hilo_i), .mul_i(mul_i),
      .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .stall_o(stall_o),
      .hilo_rdata_o(hilo_rdata_o), .mul_result_o(mul_result_o),
      .result_valid_o(result_valid_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_cnt = 0;
   bit cmp_en = 1'b0;
   logic [W-1:0] exp_hi = '0, exp_lo = '0, exp_mr = '0;
   logic         exp_stall = 1'b0, exp_rv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison of every output against the architectural model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("hi", hi_o, exp_hi);
         chk("lo", lo_o, exp_lo);
         chk("mul_result", mul_result_o, exp_mr);
         chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
         chk("result_valid", {31'b0, result_valid_o}, {31'b0, exp_rv});
         chk("hilo_rdata", hilo_rdata_o,
             (hilo_i == 2'b10) ? exp_hi : (hilo_i == 2'b01) ? exp_lo : 32'h0);
         if (stall_o) stall_cnt++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_en_i = 0; flush_i = 0; we_i = 0; hilo_i = 2'b00; sign_i = 0;
      en_c_i = 0; add_sub_i = 0; mul_i = 0;
      rs_data_i = $urandom; rt_data_i = $urandom;
   endtask

   task automatic do_mt(input logic [1:0] hl, input logic [31:0] d, input bit fl);
      cyc();
      ex_en_i = 1; we_i = 1; hilo_i = hl; rs_data_i = d; flush_i = fl;
      cyc();
      idle_inputs();
      if (!fl) begin
         if (hl == 2'b10) exp_hi = d;
         else             exp_lo = d;
      end
   endtask

   task automatic do_mf(input logic [1:0] hl);
      cyc();
      ex_en_i = 1; we_i = 0; hilo_i = hl;
      cyc();
      idle_inputs();
   endtask

   // flush_at / rst_at count cycles after the start cycle T; 0 means never
   task automatic do_mult(input bit sg, input bit ec, input bit as, input bit ml,
                          input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int rst_at);
      logic [63:0] p, old, nw;
      old = {exp_hi, exp_lo};
      if (sg) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      else    p = {32'b0, a} * {32'b0, b};
      nw = ec ? (as ? old - p : old + p) : p;
      cyc();
      stall_cnt = 0;
      ex_en_i = 1; we_i = 1; hilo_i = 2'b11; sign_i = sg; en_c_i = ec;
      add_sub_i = as; mul_i = ml; rs_data_i = a; rt_data_i = b; flush_i = 0;
      exp_stall = 1; exp_rv = 0;
      for (int i = 1; i <= LAT; i++) begin
         cyc();
         if (i == rst_at) begin
            rst = 1; ex_en_i = 0; we_i = 0; hilo_i = 2'b00;
            exp_hi = 0; exp_lo = 0; exp_mr = 0; exp_stall = 0; exp_rv = 0;
            cyc();
            rst = 0;
            return;
         end
         if (i == flush_at) begin
            flush_i = 1; exp_stall = 0; exp_rv = 0;
            cyc();
            idle_inputs();
            return;
         end
         exp_stall = (i < LAT);
         exp_rv    = (i == LAT);
      end
      cyc();
      idle_inputs();
      exp_stall = 0; exp_rv = 0;
      {exp_hi, exp_lo} = nw;
      exp_mr = p[31:0];
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1;
      idle_inputs();
      cyc();
      cmp_en = 1;
      cyc();
      rst = 0;
      cyc();

      // mult -1 x 2
      do_mult(1, 0, 0, 0, 32'hFFFFFFFF, 32'h2, 0, 0);
      chk("tp_mult_stall_cycles", stall_cnt, LAT);
      chk("tp_mult_hi", hi_o, 32'hFFFFFFFF);
      chk("tp_mult_lo", lo_o, 32'hFFFFFFFE);

      // multu 0xFFFFFFFF x 2
      do_mult(0, 0, 0, 0, 32'hFFFFFFFF, 32'h2, 0, 0);
      chk("tp_multu_hi", hi_o, 32'h00000001);
      chk("tp_multu_lo", lo_o, 32'hFFFFFFFE);

      // madd carrying out of LO, read back right after the commit
      do_mt(2'b10, 32'h0, 0);
      do_mt(2'b01, 32'hFFFFFFFF, 0);
      do_mult(1, 1, 0, 0, 32'h1, 32'h1, 0, 0);
      ex_en_i = 1; we_i = 0; hilo_i = 2'b10;
      #1 chk("tp_madd_mfhi", hilo_rdata_o, 32'h00000001);
      hilo_i = 2'b01;
      #1 chk("tp_madd_mflo", hilo_rdata_o, 32'h00000000);
      cyc();
      idle_inputs();

      // msubu 2x3 from zero, then msub -1x3 from zero
      do_mt(2'b10, 32'h0, 0);
      do_mt(2'b01, 32'h0, 0);
      do_mult(0, 1, 1, 0, 32'h2, 32'h3, 0, 0);
      chk("tp_msubu_hi", hi_o, 32'hFFFFFFFF);
      chk("tp_msubu_lo", lo_o, 32'hFFFFFFFA);
      do_mt(2'b10, 32'h0, 0);
      do_mt(2'b01, 32'h0, 0);
      do_mult(1, 1, 1, 0, 32'hFFFFFFFF, 32'h3, 0, 0);
      chk("tp_msub_hi", hi_o, 32'h00000000);
      chk("tp_msub_lo", lo_o, 32'h00000003);

      // mul most-negative x -1
      do_mult(1, 0, 0, 1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      chk("tp_mul_result", mul_result_o, 32'h80000000);
      chk("tp_mul_hi", hi_o, 32'h00000000);
      chk("tp_mul_lo", lo_o, 32'h80000000);

      // flush mid-multiply leaves HI/LO untouched
      do_mt(2'b10, 32'h12345678, 0);
      do_mt(2'b01, 32'h12345678, 0);
      do_mult(0, 0, 0, 0, 32'hDEADBEEF, 32'h12345, 10, 0);
      chk("tp_flush_hi", hi_o, 32'h12345678);
      chk("tp_flush_lo", lo_o, 32'h12345678);

      // flush in FIN suppresses the commit
      do_mult(0, 1, 0, 0, 32'h7, 32'h9, LAT, 0);
      chk("tp_flush_fin_lo", lo_o, 32'h12345678);

      // flush in IDLE suppresses both mt and the start
      do_mt(2'b10, 32'hCAFEF00D, 1);
      cyc();
      ex_en_i = 1; we_i = 1; hilo_i = 2'b11; flush_i = 1;
      rs_data_i = 32'h3; rt_data_i = 32'h5;
      cyc();
      idle_inputs();
      cyc();
      chk("tp_idle_flush_hi", hi_o, 32'h12345678);

      // asynchronous reset during BUSY
      do_mult(1, 0, 0, 0, 32'h11111111, 32'h22222222, 0, 5);
      chk("tp_rst_hi", hi_o, 32'h0);
      chk("tp_rst_lo", lo_o, 32'h0);
      chk("tp_rst_stall", {31'b0, stall_o}, 32'h0);

      // randomized mix of multiplies, moves and reads
      for (int k = 0; k < 30; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) begin
            do_mt($urandom_range(0, 1) ? 2'b10 : 2'b01, $urandom, ($urandom_range(0, 4) == 0));
         end else if (r < 3) begin
            do_mf($urandom_range(0, 1) ? 2'b10 : 2'b01);
         end else begin
            do_mult($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), pick_operand(), pick_operand(),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT) : 0, 0);
         end
      end

      repeat (3) cyc();
      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_hilo_unit.md
Name: mul_hilo_unit

Overview:
- EX-stage multiply/HI-LO datapath, directly downstream of the ID-stage multiply control decoder.
- Consumes the decoder's registered control bundle (sign, we, en_c, add_sub, HiLo, mul) plus the rs/rt operands.
- Executes mult/multu/mul/madd/maddu/msub/msubu on an iterative shift-add multiplier and owns the HI/LO registers.
- Serves mthi/mtlo writes and mfhi/mflo reads; stalls the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_en_i  in  1  instruction in EX is valid and may issue.
- flush_i  in  1  kill the EX instruction or the in-flight multiply.
- sign_i  in  1  signed operation.
- we_i  in  1  HI/LO write class.
- en_c_i  in  1  accumulate with current {HI,LO}.
- add_sub_i  in  1  0 = add to {HI,LO}, 1 = subtract from {HI,LO}.
- hilo_i  in  2  10 = HI, 01 = LO, 11 = both.
- mul_i  in  1  mul op; low product word goes to the GPR.
- rs_data_i  in  WIDTH  operand A; mthi/mtlo source.
- rt_data_i  in  WIDTH  operand B.
- stall_o  out  1  hold IF/ID/EX.
- hilo_rdata_o  out  WIDTH  mfhi/mflo read data.
- mul_result_o  out  WIDTH  low product word for mul.
- result_valid_o  out  1  one-cycle pulse: multiply finished.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Decode classes:
  - is_mult = we_i & hilo_i==11.
  - is_mt = we_i & hilo_i∈{10,01}.
  - is_mf = ~we_i & hilo_i!=00.
- Reset: state IDLE; HI, LO, accumulator, counter = 0; stall_o, result_valid_o, mul_result_o = 0.
- FSM IDLE -> BUSY -> FIN -> IDLE.
- IDLE, start condition ex_en_i & is_mult & ~flush_i:
  - stall_o is asserted combinationally in the start cycle T.
  - At the clock edge, latch |A| and |B| (absolute values only when sign_i), neg = sign_i & (A[31]^B[31]), and en_c/add_sub/mul. Clear acc and counter. Go to BUSY.
  - |0x80000000| = 0x80000000 unsigned.
- BUSY:
  - Each cycle: if multiplier bit[count] is set, acc += |A| << count. Then count++.
  - 32 cycles, T+1..T+32. stall_o = 1 throughout.
  - Go to FIN after count 31.
- FIN (T+33):
  - stall_o = 0; result_valid_o = 1.
  - p = neg ? -acc : acc (2*WIDTH, two's complement).
  - {HI,LO} <= en_c ? ({HI,LO} ± p per add_sub) : p.
  - mul_result_o <= p[31:0] for every multiply.
  - Go to IDLE; the still-present EX instruction is not re-issued.
  - New HI/LO values are visible from T+34.
- mthi/mtlo: in IDLE, ex_en_i & is_mt & ~flush_i writes rs_data_i into HI (10) or LO (01) at the edge. No stall.
- mfhi/mflo: hilo_rdata_o = HI when hilo_i==10, LO when 01, 0 otherwise. Combinational, no stall.
- Flush:
  - flush_i in BUSY or FIN: go to IDLE next edge, no HI/LO write, result_valid_o = 0, stall_o drops in that cycle.
  - flush_i in IDLE suppresses start and mt writes.
- Asynchronous reset at any point aborts the operation and restores all reset values.
- All ± arithmetic wraps modulo 2^64. No overflow flag.

Optional Feature:
- MUL_RADIX4_EN defined: BUSY consumes 2 multiplier bits per cycle, adding (|A| * bits[2k+1:2k]) << 2k.
  - 16 BUSY cycles; stall_o asserted T..T+16; FIN at T+17.
- MUL_RADIX4_EN undefined: 1 bit per cycle, timing as in Behaviour.
- Results are identical in both modes.

Test Plan:
- mult 0xFFFFFFFF × 0x00000002 -> stall_o high for exactly 33 cycles; result_valid_o at T+33; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu 0xFFFFFFFF × 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
- mthi 0, mtlo 0xFFFFFFFF, then madd 1×1 -> HI=0x00000001, LO=0x00000000; mfhi returns 0x00000001 and mflo returns 0x00000000 at T+34.
- HI=LO=0, msubu 2×3 -> {HI,LO}=0xFFFFFFFF_FFFFFFFA. msub 0xFFFFFFFF(-1)×3 from 0 -> {HI,LO}=0x00000000_00000003.
- mul 0x80000000 × 0xFFFFFFFF signed -> mul_result_o=0x80000000; HI=0x00000000, LO=0x80000000.
- flush_i at T+10 of a mult with HI=LO=0x12345678 -> HI/LO unchanged, no result_valid_o, stall_o low from T+10. Separately, rst at T+5 -> HI=LO=0, IDLE, stall_o=0 immediately.
